// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the sync_debounce input conditioner.
package sync_debounce_pkg;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel of the conditioner: synchronizer chain, stability counter,
// registered debounced level and one-cycle update strobe.
module sync_debounce_ch #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = 4,
  parameter int   CNT_W        = 2,
  parameter logic RST_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic din,
  output logic sync,
  output logic dbnc,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] chain;
  logic [CNT_W-1:0]       cnt;
  logic                   mism;

  // The chain ignores en so sync always tracks the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_BIT}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign mism = sync ^ dbnc;

  // Stability must be continuous: any agreeing cycle clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dbnc <= RST_BIT;
      upd  <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (!en || !mism) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          dbnc <= sync;
          cnt  <= '0;
          upd  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debouncer feeding the edge detector:
// a shared tick prescaler and WIDTH independent channels.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               SYNC_STAGES  = 2,
  parameter int               TICK_DIV     = 1,
  parameter int               STABLE_TICKS = 4,
  parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dbnc_out,
  output logic [WIDTH-1:0] upd_pulse,
  output logic             busy
);

  localparam int CNT_W = min1_clog2(STABLE_TICKS);
  localparam int PW    = min1_clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TICK_DIV < 1 || STABLE_TICKS < 1) begin : g_bad_param
    $error("sync_debounce: illegal parameter combination");
  end

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [WIDTH-1:0] sync;

  // Prescaler restarts from zero whenever en drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!en || pcnt == P_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = en && (pcnt == P_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .CNT_W       (CNT_W),
      .RST_BIT     (RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .tick (tick),
      .din  (din[i]),
      .sync (sync[i]),
      .dbnc (dbnc_out[i]),
      .upd  (upd_pulse[i])
    );
  end

  assign busy = |(sync ^ dbnc_out);

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: a default instance (a) and a prescaled one
// (b, TICK_DIV=10, STABLE_TICKS=3) driven by the same inputs.
module tb_sync_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] din;
  logic [7:0] dbnc_a, upd_a, dbnc_b, upd_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sync_debounce dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dbnc_out(dbnc_a), .upd_pulse(upd_a), .busy(busy_a)
  );

  sync_debounce #(.TICK_DIV(10), .STABLE_TICKS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dbnc_out(dbnc_b), .upd_pulse(upd_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs seen by the rising edge, captured for the model step at the next falling edge.
  logic       rst_s, en_s;
  logic [7:0] din_s;
  always @(posedge clk) begin
    rst_s <= rst_n;
    en_s  <= en;
    din_s <= din;
  end

  int         m_ss [2] = '{2, 2};
  int         m_td [2] = '{1, 10};
  int         m_st [2] = '{4, 3};
  logic [7:0] m_hist [2][4];   // m_hist[i][k]: din captured k+1 edges ago
  logic [7:0] m_out [2];
  logic [7:0] m_upd [2];
  int         m_run [2];       // consecutive enabled cycles
  int         m_cnt [2][8];    // consecutive mismatching ticks per bit
  logic [7:0] exp_q[$];        // expected dbnc_a value at each dut_a update

  task automatic model_step();
    logic [7:0] pre;
    bit         tk;
    for (int i = 0; i < 2; i++) begin
      if (!rst_s) begin
        for (int k = 0; k < 4; k++) m_hist[i][k] = '0;
        for (int b = 0; b < 8; b++) m_cnt[i][b] = 0;
        m_out[i] = '0;
        m_upd[i] = '0;
        m_run[i] = 0;
      end else begin
        pre = m_hist[i][m_ss[i]-1];
        if (en_s) begin
          m_run[i]++;
          tk = (m_run[i] % m_td[i]) == 0;
        end else begin
          m_run[i] = 0;
          tk = 1'b0;
        end
        m_upd[i] = '0;
        for (int b = 0; b < 8; b++) begin
          if (!en_s || pre[b] == m_out[i][b]) m_cnt[i][b] = 0;
          else if (tk) begin
            m_cnt[i][b]++;
            if (m_cnt[i][b] == m_st[i]) begin
              m_out[i][b] = pre[b];
              m_upd[i][b] = 1'b1;
              m_cnt[i][b] = 0;
            end
          end
        end
        for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = din_s;
        if (i == 0 && m_upd[0] != 0) exp_q.push_back(m_out[0]);
      end
    end
  endtask

  // ---------------- scoreboard: every cycle, both instances ----------------
  always @(negedge clk) begin
    model_step();
    check("a_dbnc", dbnc_a, m_out[0]);
    check("a_upd",  upd_a,  m_upd[0]);
    check("a_busy", busy_a, |(m_hist[0][m_ss[0]-1] ^ m_out[0]));
    check("b_dbnc", dbnc_b, m_out[1]);
    check("b_upd",  upd_b,  m_upd[1]);
    check("b_busy", busy_b, |(m_hist[1][m_ss[1]-1] ^ m_out[1]));
    if (upd_a != 0) begin
      if (exp_q.size() == 0) check("sb_unexpected_update", upd_a, 8'h00);
      else check("sb_update_value", dbnc_a, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Call right after a falling edge (or at time 0).
  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Falling edges (one per rising edge) until a masked update strobe is seen.
  task automatic edges_until(input int inst, input logic [7:0] mask, input int limit,
                             output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((((inst == 0) ? upd_a : upd_b) & mask) == 0 && n < limit);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       en;
    int         hold;
    logic [7:0] exp_dbnc;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];
  int   n, pulses, pulse_c;
  bit   saw_busy;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 10, 8'hA5, 1'b0};
    vecs[1] = '{8'h5A, 1'b0, 10, 8'hA5, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 10, 8'h5A, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 3,  8'h5A, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 10, 8'h00, 1'b0};

    rst_n = 1'b0;
    en    = 1'b1;
    din   = 8'h00;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_dbnc_a", dbnc_a, 8'h00);
    check("reset_upd_a",  upd_a,  8'h00);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_dbnc_b", dbnc_b, 8'h00);

    // Default latency: capture edge counted as edge 1
    din = 8'h01;
    edges_until(0, 8'h01, 20, n);
    check("latency_edges", n, 6);
    check("latency_dbnc", dbnc_a, 8'h01);
    check("latency_upd",  upd_a,  8'h01);
    check("latency_busy", busy_a, 1'b0);
    @(negedge clk);
    check("latency_upd_one_cycle", upd_a, 8'h00);

    // Glitch on bit 3 lasting three cycles
    pulses = 0;
    saw_busy = 1'b0;
    for (int c = 0; c < 13; c++) begin
      din = (c < 3) ? 8'h09 : 8'h01;
      @(negedge clk);
      if (upd_a != 0) pulses++;
      saw_busy |= busy_a;
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_dbnc", dbnc_a, 8'h01);
    check("glitch_busy_seen", saw_busy, 1'b1);
    check("glitch_busy_end", busy_a, 1'b0);

    // Bounce on bit 5, final rise applied before edge 9
    pulses = 0;
    pulse_c = -1;
    for (int c = 0; c < 24; c++) begin
      din = (c >= 8 || ((c / 2) % 2) == 0) ? 8'h21 : 8'h01;
      @(negedge clk);
      if (upd_a[5]) begin
        pulses++;
        pulse_c = c;
      end
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_pulse_cycle", pulse_c, 13);
    check("bounce_dbnc", dbnc_a, 8'h21);

    // Table-driven vectors on the default instance
    foreach (vecs[v]) begin
      din = vecs[v].din;
      en  = vecs[v].en;
      repeat (vecs[v].hold) @(negedge clk);
      check($sformatf("vec%0d_dbnc", v), dbnc_a, vecs[v].exp_dbnc);
      check($sformatf("vec%0d_busy", v), busy_a, vecs[v].exp_busy);
    end

    // Prescaled instance: ticks every 10 cycles, 3 ticks needed
    do_reset();
    din = 8'hFF;
    edges_until(1, 8'hFF, 60, n);
    check("presc_edges", n, 30);
    check("presc_upd",  upd_b,  8'hFF);
    check("presc_dbnc", dbnc_b, 8'hFF);

    // Enable freeze
    @(negedge clk);
    en  = 1'b0;
    din = 8'h0F;
    repeat (50) @(negedge clk);
    check("freeze_dbnc_a", dbnc_a, 8'hFF);
    check("freeze_dbnc_b", dbnc_b, 8'hFF);
    check("freeze_upd_a",  upd_a,  8'h00);
    check("freeze_busy_a", busy_a, 1'b1);
    en = 1'b1;
    edges_until(0, 8'hF0, 20, n);
    check("unfreeze_edges", n, 4);
    check("unfreeze_dbnc", dbnc_a, 8'h0F);

    // Reset while bits 4..7 are at count 2 of 4
    @(negedge clk);
    din = 8'hFF;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_dbnc_a", dbnc_a, 8'h00);
    check("midrst_upd_a",  upd_a,  8'h00);
    check("midrst_busy_a", busy_a, 1'b0);
    check("midrst_dbnc_b", dbnc_b, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges_until(0, 8'hFF, 20, n);
    check("midrst_restart_edges", n, 6);
    check("midrst_restart_dbnc", dbnc_a, 8'hFF);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      if ($urandom_range(0, 3) == 0) din ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) din = din;
      if (en && $urandom_range(0, 63) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      if ($urandom_range(0, 599) == 0) #1 rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
